// File: rtl/apb_regfile_slave.sv
// APB completer with a word-addressed register file and fixed wait-state insertion.
// Register 0 drives ctrl_out; register 1 reads back status_in and rejects writes.
module apb_regfile_slave #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    input  logic [DATA_WIDTH-1:0] status_in
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
    localparam int unsigned REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    wr_en;
    logic                    ready;
    logic [IDX_W-1:0]        idx;
    logic [REG_IDX_W-1:0]    reg_idx;
    logic                    err_misalign;
    logic                    err_range;
    logic                    err_ro;
    logic                    err_any;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Address decode works only on the latched setup-phase values
    assign idx          = addr_q[ADDR_WIDTH-1:2];
    assign reg_idx      = idx[REG_IDX_W-1:0];
    assign err_misalign = |addr_q[1:0];
    assign err_range    = ({1'b0, idx} >= (IDX_W + 1)'(NUM_REGS));
    assign err_ro       = write_q && (idx == IDX_W'(1));
    assign err_any      = err_misalign || err_range || err_ro;

    assign ready   = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign rd_word = (reg_idx == REG_IDX_W'(1)) ? status_in : regs_q[reg_idx];

    assign PREADY   = ready;
    assign PSLVERR  = ready && err_any;
    assign PRDATA   = (ready && !write_q && !err_any) ? rd_word : '0;
    assign ctrl_out = regs_q[0];

    // State, wait counter and latched transfer attributes
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // PSEL with PENABLE already high is a protocol violation and is ignored
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (PENABLE) begin
                    state_d = ST_IDLE;
                    wr_en   = write_q && !err_any;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register file; slot 1 is never written because err_ro blocks it
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            regs_q <= '{default: '0};
        end else if (wr_en) begin
            regs_q[reg_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: two completers (2 wait states and zero wait states) on a shared APB bus.
module tb_apb_regfile_slave;

    typedef struct {
        logic        which;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        psel_a;
    logic        psel_b;
    logic        penable;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] status;
    logic [31:0] prdata_a, prdata_b, ctrl_a, ctrl_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(2)) u_dut_a (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_a), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .ctrl_out(ctrl_a), .status_in(status)
    );

    apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) u_dut_b (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_b), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .ctrl_out(ctrl_b), .status_in(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor side of the scoreboard: one DUT per call, sampled on the falling edge
    task automatic mon_dut(input logic which, input logic rdy, input logic err, input logic [31:0] rd);
        exp_t e;
        if (rdy) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pready: dut %0d raised PREADY with nothing outstanding", which);
            end else begin
                e = q.pop_front();
                check("resp_dut", 64'(which), 64'(e.which));
                check("pslverr", 64'(err), 64'(e.err));
                if (e.chk_rdata) check("prdata", 64'(rd), 64'(e.rdata));
            end
        end else begin
            check("idle_zero", 64'({err, rd}), 64'(0));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_dut(1'b0, pready_a, pslverr_a, prdata_a);
            mon_dut(1'b1, pready_b, pslverr_b, prdata_b);
        end
    end

    // Driver: called at posedge+1, returns at posedge+1 right after the completion edge
    task automatic xfer(input logic which, input logic [7:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input int exp_acc);
        exp_t e;
        int   cyc;
        logic done;
        e.which = which; e.rdata = exp_rdata; e.err = exp_err; e.chk_rdata = !wr;
        q.push_back(e);
        paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
        if (which) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            done = which ? pready_b : pready_a;
        end
        check("access_cycles", 64'(cyc), 64'(exp_acc));
        @(posedge clk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic seen;
        status  = 32'hCAFE_0001;
        rst_n   = 1'b0;
        psel_a  = 1'b0; psel_b = 1'b0; penable = 1'b0;
        paddr   = '0;   pwrite = 1'b0; pwdata  = '0;

        @(negedge clk);
        check("in_reset_outputs", 64'({pready_a, pslverr_a, prdata_a}), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_ctrl", 64'({ctrl_a, ctrl_b}), 64'(0));
            check("reset_pready", 64'({pready_a, pready_b}), 64'(0));
        end
        @(posedge clk); #1;

        // Basic write/read and ctrl_out on the 2-wait-state completer
        xfer(1'b0, 8'h08, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 3);
        xfer(1'b0, 8'h08, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        xfer(1'b0, 8'h00, 1'b1, 32'h0000_00A5, 1'b0, 32'h0, 3);
        check("ctrl_after_write", 64'(ctrl_a), 64'(32'h0000_00A5));
        check("ctrl_other_dut", 64'(ctrl_b), 64'(0));

        // Error responses
        xfer(1'b0, 8'h40, 1'b0, 32'h0, 1'b1, 32'h0, 3);
        xfer(1'b0, 8'h05, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 3);
        xfer(1'b0, 8'h04, 1'b0, 32'h0, 1'b0, 32'hCAFE_0001, 3);
        xfer(1'b0, 8'h09, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 3);
        xfer(1'b0, 8'h08, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        xfer(1'b0, 8'h04, 1'b1, 32'h0000_1234, 1'b1, 32'h0, 3);
        xfer(1'b0, 8'h04, 1'b0, 32'h0, 1'b0, 32'hCAFE_0001, 3);
        xfer(1'b0, 8'h3C, 1'b1, 32'h3C3C_3C3C, 1'b0, 32'h0, 3);
        xfer(1'b0, 8'h3C, 1'b0, 32'h0, 1'b0, 32'h3C3C_3C3C, 3);
        xfer(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0000_00A5, 3);

        // Zero-wait completer, back-to-back with no idle cycles
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 8'(8'h0C + 4 * i), 1'b1, 32'hB000_000C + 32'(4 * i), 1'b0, 32'h0, 1);
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 8'(8'h0C + 4 * i), 1'b0, 32'h0, 1'b0, 32'hB000_000C + 32'(4 * i), 1);
        xfer(1'b1, 8'h08, 1'b0, 32'h0, 1'b0, 32'h0, 1);

        // Abort: PSEL drops in the first wait cycle
        xfer(1'b0, 8'h10, 1'b1, 32'h1111_2222, 1'b0, 32'h0, 3);
        paddr = 8'h10; pwrite = 1'b1; pwdata = 32'h0000_0055; psel_a = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | pready_a;
        end
        check("abort_no_pready", 64'(seen), 64'(0));
        @(posedge clk); #1;
        xfer(1'b0, 8'h10, 1'b0, 32'h0, 1'b0, 32'h1111_2222, 3);

        // Asynchronous reset in the middle of a write to register 0
        paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h0000_0077; psel_a = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("ctrl_before_reset", 64'(ctrl_a), 64'(32'h0000_00A5));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({pready_a, pslverr_a, prdata_a}), 64'(0));
        check("async_reset_ctrl", 64'(ctrl_a), 64'(0));
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 3);
        xfer(1'b0, 8'h08, 1'b0, 32'h0, 1'b0, 32'h0, 3);
        check("ctrl_after_reset_read", 64'(ctrl_a), 64'(0));

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
APB completer (slave) that answers transfers from the team's APB master state machine (IDLE/SETUP/ENABLE with PREADY-terminated access).
- Holds a small word-addressed register file.
- Inserts a fixed, parameterised number of wait states.
- Signals errors on PSLVERR.
- Register 0 drives a control output; register 1 is a read-only status input.

Parameters:
ADDR_WIDTH, 8, width of PADDR (byte address)
DATA_WIDTH, 32, width of PWDATA/PRDATA and of each register
NUM_REGS, 16, number of 32-bit registers; valid byte addresses 0x00..(NUM_REGS*4-4); must be >=2 and <=2^(ADDR_WIDTH-2)
WAIT_CYCLES, 2, wait states per transfer (0..15); PREADY rises WAIT_CYCLES cycles after the first access cycle

Ports:
PCLK  in  1  APB clock; all state on rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select from master
PENABLE  in  1  access-phase indicator
PADDR  in  ADDR_WIDTH  byte address
PWRITE  in  1  1=write, 0=read
PWDATA  in  DATA_WIDTH  write data
PRDATA  out  DATA_WIDTH  read data, valid only when PREADY=1
PREADY  out  1  transfer completion
PSLVERR  out  1  error response, valid only when PREADY=1
ctrl_out  out  DATA_WIDTH  current value of register 0
status_in  in  DATA_WIDTH  value returned on reads of register 1

Behaviour:
- Interface: reset PRESETn, asynchronous, active-low; clock PCLK.
- Reset:
  - state=IDLE, wait counter=0.
  - All registers 0, so ctrl_out=0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - Reset asserted mid-transfer aborts it with no register update.
- States: IDLE, ACCESS.
- IDLE:
  - PREADY=0.
  - On PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA.
  - Load counter with WAIT_CYCLES and go to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignore it and stay IDLE.
- ACCESS:
  - PREADY = (counter==0), decoded from registered state only, with no combinational path from APB inputs.
  - If counter!=0: decrement it; PREADY=0.
  - If counter==0 and PSEL=1 and PENABLE=1: the transfer completes this cycle.
    - Write: update the register at the rising edge.
    - Next state is IDLE.
  - If PSEL=0 during ACCESS: abort, go to IDLE, no register update.
- Latency:
  - Setup cycle, then WAIT_CYCLES cycles with PREADY=0, then 1 cycle with PREADY=1.
  - Access phase is WAIT_CYCLES+1 cycles.
  - WAIT_CYCLES=0 gives a zero-wait 2-cycle transfer.
- Back-to-back: a completed transfer returns to IDLE. A setup phase presented in the next cycle is accepted, so there are no dead cycles between transfers.
- Decode, using the latched address:
  - index = addr[ADDR_WIDTH-1:2].
  - err_misalign = addr[1:0]!=0.
  - err_range = index>=NUM_REGS.
  - err_ro = write and index==1.
  - PSLVERR = PREADY and (any error).
- Errored transfers still complete with the normal wait count. An errored write changes no register; an errored read returns PRDATA=0.
- Reads:
  - PRDATA = register[index] when PREADY=1 and there is no error; index 1 returns status_in sampled in that cycle.
  - PRDATA=0 whenever PREADY=0.
- Writes: full-word only, with no byte strobes; the value is visible on the next read and on ctrl_out in the cycle after completion.
- Outputs PSLVERR and PRDATA are forced to 0 outside the completion cycle.

Test Plan:
- Reset then idle: PRESETn low 3 cycles, release; PSEL=0 for 5 cycles -> PREADY=0, PSLVERR=0, PRDATA=0, ctrl_out=0 throughout.
- Write/read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x08 -> PREADY high exactly 3 cycles after PENABLE rises, PSLVERR=0.
  - Read 0x08 -> PRDATA=0xDEADBEEF in the PREADY cycle.
  - Write 0x0000_00A5 to 0x00 -> ctrl_out=0x000000A5 the cycle after completion.
- Errors:
  - Read 0x40 (NUM_REGS=16) -> PSLVERR=1, PRDATA=0.
  - Write to 0x05 -> PSLVERR=1; a later read of 0x04 is unchanged.
  - Write 0x1234 to 0x04 -> PSLVERR=1; a read of 0x04 returns status_in (drive 0xCAFE0001).
- Back-to-back with WAIT_CYCLES=0: four consecutive writes to 0x0C..0x18 with no idle cycles -> each completes in 2 cycles, PREADY high every second cycle; readback matches.
- Abort: PSEL drops during the first wait cycle of a write of 0x55 to 0x10 -> PREADY never asserts, register 0x10 keeps its old value, and the next setup is accepted normally.
- Reset mid-transfer: PRESETn pulsed low during the wait state of a write to 0x00 -> all outputs 0 immediately (asynchronous), ctrl_out=0, and a subsequent read of 0x00 returns 0.
